cr_countdown: RTL and testbench

Countdown stage of the chronometer (timer) path. It loads the latched hour/minute/second timer settings from the timer setting registers and decrements them once per 1 Hz tick. It stops at 00:00:00 and raises a ring indication for the display/alarm logic. All values are packed BCD, two digits per byte, matching the timer setting registers.

---
 rtl/cr_pkg.sv | 7 +
 rtl/cr_countdown_bcd_dec_2d.sv | 19 +
 rtl/cr_countdown.sv | 113 +++++++++++
 tb/tb_cr_countdown.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cr_pkg.sv
// cr_pkg: shared state encoding and BCD constants for the chronometer countdown
package cr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;
  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [23:0] TIME_ZERO = {BCD_00, BCD_00, BCD_00};
endpackage

// File: rtl/cr_countdown_bcd_dec_2d.sv
// bcd_dec_2d: two-digit packed BCD decrement with borrow chaining and selectable tens wrap
module bcd_dec_2d (
  input  logic [7:0] val,
  input  logic       borrow_in,
  input  logic [3:0] tens_max,
  output logic [7:0] res,
  output logic       borrow_out
);
  logic u_wrap;
  logic t_wrap;
  // units wrap 0->9 and borrow from tens; tens wrap 0->tens_max and borrow out
  always_comb begin
    u_wrap = borrow_in && val[3:0] == 4'd0;
    t_wrap = u_wrap && val[7:4] == 4'd0;
    res[3:0] = !borrow_in ? val[3:0] : u_wrap ? 4'd9 : val[3:0] - 4'd1;
    res[7:4] = !u_wrap ? val[7:4] : t_wrap ? tens_max : val[7:4] - 4'd1;
    borrow_out = t_wrap;
  end
endmodule

// File: rtl/cr_countdown.sv
// cr_countdown: BCD hh:mm:ss countdown with load validation and ring; CR_RING_TIMEOUT_EN adds ring auto-clear
module cr_countdown
  import cr_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX  = 8'h23,
  parameter int         RING_SECS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  input  logic [7:0] dato_cr_hor,
  input  logic [7:0] dato_cr_min,
  input  logic [7:0] dato_cr_seg,
  output logic [7:0] cnt_hor,
  output logic [7:0] cnt_min,
  output logic [7:0] cnt_seg,
  output logic       running,
  output logic       ring,
  output logic       done,
  output logic       load_err
);
  state_t state, state_n;
  logic [7:0] hor_n, min_n, seg_n, dec_hor, dec_min, dec_seg;
  logic b_seg, b_min, unused_hor_borrow;
  logic valid, done_n, err_n;
`ifdef CR_RING_TIMEOUT_EN
  localparam int RW = $clog2(RING_SECS + 1);
  logic [RW-1:0] ring_cnt, ring_cnt_n;
`endif
  bcd_dec_2d u_seg (.val(cnt_seg), .borrow_in(1'b1), .tens_max(4'd5), .res(dec_seg), .borrow_out(b_seg));
  bcd_dec_2d u_min (.val(cnt_min), .borrow_in(b_seg), .tens_max(4'd5), .res(dec_min), .borrow_out(b_min));
  bcd_dec_2d u_hor (.val(cnt_hor), .borrow_in(b_min), .tens_max(4'd9), .res(dec_hor), .borrow_out(unused_hor_borrow));
  // a load is accepted only if every digit is decimal and each field is within its range
  always_comb begin
    valid = dato_cr_hor[3:0] <= 4'd9 && dato_cr_hor[7:4] <= 4'd9 &&
            dato_cr_min[3:0] <= 4'd9 && dato_cr_min[7:4] <= 4'd9 &&
            dato_cr_seg[3:0] <= 4'd9 && dato_cr_seg[7:4] <= 4'd9 &&
            dato_cr_min <= BCD_59 && dato_cr_seg <= BCD_59 && dato_cr_hor <= HOUR_MAX;
  end
  // highest-priority asserted pulse selects the action; lower pulses that cycle are dropped
  always_comb begin
    state_n = state;
    hor_n = cnt_hor;
    min_n = cnt_min;
    seg_n = cnt_seg;
    done_n = 1'b0;
    err_n = 1'b0;
`ifdef CR_RING_TIMEOUT_EN
    ring_cnt_n = ring_cnt;
`endif
    if (load) begin
      if (state != RUN) begin
        if (valid) begin
          hor_n = dato_cr_hor;
          min_n = dato_cr_min;
          seg_n = dato_cr_seg;
          state_n = state == RING ? IDLE : state;
        end else err_n = 1'b1;
      end
    end else if (ack) state_n = state == RING ? IDLE : state;
    else if (stop) state_n = state == RUN ? PAUSE : state;
    else if (start) state_n = (state == PAUSE || (state == IDLE && {cnt_hor, cnt_min, cnt_seg} != TIME_ZERO)) ? RUN : state;
    else if (tick_1hz && state == RUN) begin
      hor_n = dec_hor;
      min_n = dec_min;
      seg_n = dec_seg;
      if ({dec_hor, dec_min, dec_seg} == TIME_ZERO) begin
        done_n = 1'b1;
        state_n = RING;
      end
    end
`ifdef CR_RING_TIMEOUT_EN
    else if (tick_1hz && state == RING) begin
      ring_cnt_n = ring_cnt + 1'b1;
      if (ring_cnt == RW'(RING_SECS - 1)) state_n = IDLE;
    end
    if (state_n == RING && state != RING) ring_cnt_n = '0;
`endif
  end
  // register state, counts and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt_hor <= BCD_00;
      cnt_min <= BCD_00;
      cnt_seg <= BCD_00;
      running <= 1'b0;
      ring <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt_hor <= hor_n;
      cnt_min <= min_n;
      cnt_seg <= seg_n;
      running <= state_n == RUN;
      ring <= state_n == RING;
      done <= done_n;
      load_err <= err_n;
    end
  end
`ifdef CR_RING_TIMEOUT_EN
  // ring timeout tick counter
  always_ff @(posedge clk) begin
    if (reset) ring_cnt <= '0;
    else ring_cnt <= ring_cnt_n;
  end
`endif
endmodule

// File: tb/tb_cr_countdown.sv
// tb_cr_countdown: directed plus randomized scoreboard bench against a seconds-count reference model
module tb_cr_countdown;
  localparam int RS = 3;
  logic clk = 1'b0;
  logic reset, tick_1hz, load, start, stop, ack;
  logic [7:0] dato_cr_hor, dato_cr_min, dato_cr_seg;
  logic [7:0] cnt_hor, cnt_min, cnt_seg;
  logic running, ring, done, load_err;
  typedef struct packed {
    logic [7:0] h, m, s;
    logic run, rng, dn, err;
  } exp_t;
  exp_t q[$];
  int passed = 0;
  int total = 0;
  int m_secs = 0;
  int m_st = 0;
  int m_rt = 0;
  bit m_done, m_err;

  cr_countdown #(.HOUR_MAX(8'h23), .RING_SECS(RS)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load), .start(start), .stop(stop), .ack(ack),
    .dato_cr_hor(dato_cr_hor), .dato_cr_min(dato_cr_min), .dato_cr_seg(dato_cr_seg),
    .cnt_hor(cnt_hor), .cnt_min(cnt_min), .cnt_seg(cnt_seg),
    .running(running), .ring(ring), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int from_bcd(logic [7:0] b);
    return 32'(b[7:4]) * 10 + 32'(b[3:0]);
  endfunction

  task automatic cy(bit r, bit ld, bit st, bit sp, bit ak, bit tk, logic [7:0] h, logic [7:0] m, logic [7:0] s);
    bit ok;
    exp_t e;
    @(negedge clk);
    #1;
    reset = r; load = ld; start = st; stop = sp; ack = ak; tick_1hz = tk;
    dato_cr_hor = h; dato_cr_min = m; dato_cr_seg = s;
    m_done = 0;
    m_err = 0;
    if (r) begin
      m_secs = 0;
      m_st = 0;
    end else if (ld) begin
      if (m_st != 1) begin
        ok = h[3:0] <= 9 && h[7:4] <= 9 && m[3:0] <= 9 && m[7:4] <= 9 && s[3:0] <= 9 && s[7:4] <= 9 &&
             from_bcd(h) <= 23 && from_bcd(m) <= 59 && from_bcd(s) <= 59;
        if (ok) begin
          m_secs = from_bcd(h) * 3600 + from_bcd(m) * 60 + from_bcd(s);
          if (m_st == 3) m_st = 0;
        end else m_err = 1;
      end
    end else if (ak) begin
      if (m_st == 3) m_st = 0;
    end else if (sp) begin
      if (m_st == 1) m_st = 2;
    end else if (st) begin
      if (m_st == 2 || (m_st == 0 && m_secs != 0)) m_st = 1;
    end else if (tk) begin
      if (m_st == 1) begin
        m_secs--;
        if (m_secs == 0) begin
          m_done = 1;
          m_st = 3;
          m_rt = 0;
        end
      end
`ifdef CR_RING_TIMEOUT_EN
      else if (m_st == 3) begin
        m_rt++;
        if (m_rt == RS) m_st = 0;
      end
`endif
    end
    e.h = to_bcd(m_secs / 3600);
    e.m = to_bcd((m_secs / 60) % 60);
    e.s = to_bcd(m_secs % 60);
    e.run = m_st == 1;
    e.rng = m_st == 3;
    e.dn = m_done;
    e.err = m_err;
    q.push_back(e);
  endtask

  task automatic ld3(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    cy(0, 1, 0, 0, 0, 0, h, m, s);
  endtask

  task automatic nop(int n);
    repeat (n) cy(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tk(int n);
    repeat (n) cy(0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic go();
    cy(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic halt();
    cy(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{cnt_hor, cnt_min, cnt_seg, running, ring, done, load_err};
        total++;
        if (a == e) passed++;
        else $display("FAIL outputs check %0d: got h=%h m=%h s=%h run=%b ring=%b done=%b err=%b, want h=%h m=%h s=%h run=%b ring=%b done=%b err=%b",
                      total, a.h, a.m, a.s, a.run, a.rng, a.dn, a.err, e.h, e.m, e.s, e.run, e.rng, e.dn, e.err);
      end
    end
  end

  initial begin
    logic [7:0] h, m, s;
    reset = 1; load = 0; start = 0; stop = 0; ack = 0; tick_1hz = 0;
    dato_cr_hor = 0; dato_cr_min = 0; dato_cr_seg = 0;
    cy(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cy(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    total++;
    if ({cnt_hor, cnt_min, cnt_seg} == 24'h0 && !running && !ring && !done && !load_err) passed++;
    else $display("FAIL reset-state check: h=%h m=%h s=%h run=%b ring=%b done=%b err=%b",
                  cnt_hor, cnt_min, cnt_seg, running, ring, done, load_err);
    ld3(8'h00, 8'h01, 8'h00); go(); tk(1); nop(1); halt();
    ld3(8'h01, 8'h00, 8'h00); go(); tk(1); nop(1); halt();
    ld3(8'h00, 8'h00, 8'h02); go(); tk(2); nop(2);
    cy(0, 0, 0, 0, 1, 0, 0, 0, 0); nop(1);
    ld3(8'h00, 8'h60, 8'h00); ld3(8'h24, 8'h00, 8'h00); ld3(8'h00, 8'h0A, 8'h00); ld3(8'h00, 8'h00, 8'h60);
    go(); nop(1);
    ld3(8'h00, 8'h00, 8'h10); go(); halt(); tk(3); go(); tk(1); halt();
    cy(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h05);
    cy(0, 0, 1, 1, 0, 0, 0, 0, 0);
    go(); tk(5); tk(4); nop(1);
    ld3(8'h23, 8'h59, 8'h59); go(); tk(2);
    cy(1, 0, 0, 0, 0, 0, 0, 0, 0); nop(2);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: begin h = 8'($urandom); m = 8'($urandom); s = 8'($urandom); end
        1: begin h = to_bcd($urandom_range(0, 23)); m = to_bcd($urandom_range(0, 59)); s = to_bcd($urandom_range(0, 59)); end
        default: begin h = 8'h00; m = to_bcd($urandom_range(0, 1)); s = to_bcd($urandom_range(0, 59)); end
      endcase
      cy($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
         $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 2) == 0, h, m, s);
    end
    nop(1);
    repeat (3) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL expired-wait check: %0d expected records never compared", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
